// File: rtl/sbox_share_if.sv
// Handshake/bus bundle between the two S-box requesters (round datapath,
// key schedule) and the shared S-box controller.
interface sbox_share_if;
  logic         st_req;
  logic [127:0] st_in;
  logic         st_gnt;
  logic         st_done;
  logic [127:0] st_out;
  logic         kw_req;
  logic [31:0]  kw_in;
  logic         kw_gnt;
  logic         kw_done;
  logic [31:0]  kw_out;
  logic         busy;

  modport master (
    output st_req, st_in, kw_req, kw_in,
    input  st_gnt, st_done, st_out, kw_gnt, kw_done, kw_out, busy
  );

  modport slave (
    input  st_req, st_in, kw_req, kw_in,
    output st_gnt, st_done, st_out, kw_gnt, kw_done, kw_out, busy
  );
endinterface

// File: rtl/sbox_share_ctrl.sv
// Shared AES forward S-box bank. Two requesters (128-bit SubBytes state,
// 32-bit SubWord key word) are round-robin arbitrated; the granted operand
// is captured into a work buffer and LANES bytes per cycle are substituted
// in place until the operand is done.

// One S-box lane: multiplicative inverse in GF(2^8) followed by the AES
// affine transform.
module sbox_lane (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] sq;

  // inverse as din^254 (254 = 0b11111110); 0 maps to 0 naturally
  always_comb begin
    inv = 8'h01;
    sq  = din;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  assign dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module sbox_share_ctrl #(
  parameter int LANES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  sbox_share_if.slave bus
);
  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("sbox_share_ctrl: LANES must be 1, 2 or 4");
  end

  localparam int ST_BATCHES = 16 / LANES;
  localparam int KW_BATCHES = 4 / LANES;

  typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN} state_t;

  state_t                   state, state_nx;
  logic [3:0]               cnt;
  logic                     prio_kw;
  logic [0:15][7:0]         wbuf, wbuf_nx;   // byte i at wbuf[i] (MSB first)
  logic [3:0]               base;
  logic                     last;
  logic                     gnt_st, gnt_kw;
  logic [LANES-1:0][3:0]    idx;
  logic [LANES-1:0][7:0]    lane_in, lane_out;
  logic [127:0]             st_out_q;
  logic [31:0]              kw_out_q;
  logic                     st_done_q, kw_done_q;

  // Key words live in the low four buffer bytes
  assign base = (state == KW_RUN) ? 4'd12 : 4'd0;
  assign last = (state == ST_RUN) ? (cnt == 4'(ST_BATCHES - 1))
                                  : (cnt == 4'(KW_BATCHES - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign idx[l]     = 4'(int'(base) + int'(cnt) * LANES + l);
    assign lane_in[l] = wbuf[idx[l]];
    sbox_lane u_lane (.din(lane_in[l]), .dout(lane_out[l]));
  end

  // Arbitration: grants only from IDLE; on a tie the prio side wins.
  // Gated by reset so every output reads 0 while reset is held.
  always_comb begin
    gnt_st = 1'b0;
    gnt_kw = 1'b0;
    if (state == IDLE && rst_n) begin
      if (bus.st_req && bus.kw_req) begin
        if (prio_kw) gnt_kw = 1'b1;
        else         gnt_st = 1'b1;
      end else begin
        gnt_st = bus.st_req;
        gnt_kw = bus.kw_req;
      end
    end
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (gnt_st)      state_nx = ST_RUN;
        else if (gnt_kw) state_nx = KW_RUN;
      end
      ST_RUN, KW_RUN: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Buffer with the current batch substituted in place
  always_comb begin
    wbuf_nx = wbuf;
    if (state != IDLE) begin
      for (int l = 0; l < LANES; l++) wbuf_nx[idx[l]] = lane_out[l];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Capture, per-batch write-back, result load and done pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      prio_kw   <= 1'b1;
      wbuf      <= '0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
    end else begin
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_st) begin
            wbuf    <= bus.st_in;
            cnt     <= '0;
            prio_kw <= 1'b1;
          end else if (gnt_kw) begin
            wbuf    <= {96'b0, bus.kw_in};
            cnt     <= '0;
            prio_kw <= 1'b0;
          end
        end
        ST_RUN: begin
          wbuf <= wbuf_nx;
          cnt  <= cnt + 4'd1;
          if (last) begin
            st_out_q  <= wbuf_nx;
            st_done_q <= 1'b1;
          end
        end
        KW_RUN: begin
          wbuf <= wbuf_nx;
          cnt  <= cnt + 4'd1;
          if (last) begin
            kw_out_q  <= wbuf_nx[12:15];
            kw_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.st_gnt  = gnt_st;
  assign bus.kw_gnt  = gnt_kw;
  assign bus.st_done = st_done_q;
  assign bus.kw_done = kw_done_q;
  assign bus.st_out  = st_out_q;
  assign bus.kw_out  = kw_out_q;
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: three instances (LANES = 4, 2, 1) share clock and
// reset; results are predicted from the AES S-box table and latency rule.
module tb_sbox_share_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         st_req [3];
  logic [127:0] st_in  [3];
  logic         kw_req [3];
  logic [31:0]  kw_in  [3];
  logic         st_gnt_w [3];
  logic         st_done_w[3];
  logic [127:0] st_out_w [3];
  logic         kw_gnt_w [3];
  logic         kw_done_w[3];
  logic [31:0]  kw_out_w [3];
  logic         busy_w   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    sbox_share_if bif ();
    sbox_share_ctrl #(.LANES(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
    assign bif.st_req    = st_req[g];
    assign bif.st_in     = st_in[g];
    assign bif.kw_req    = kw_req[g];
    assign bif.kw_in     = kw_in[g];
    assign st_gnt_w[g]   = bif.st_gnt;
    assign st_done_w[g]  = bif.st_done;
    assign st_out_w[g]   = bif.st_out;
    assign kw_gnt_w[g]   = bif.kw_gnt;
    assign kw_done_w[g]  = bif.kw_done;
    assign kw_out_w[g]   = bif.kw_out;
    assign busy_w[g]     = bif.busy;
  end

  // Standard AES forward S-box, row-major
  logic [2047:0] tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_st [3];
  logic [31:0]  exp_kw [3];

  function automatic int lanes_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
  endfunction

  function automatic logic [127:0] model_sub(input logic [127:0] opnd, input int nb);
    logic [127:0] r;
    int v;
    r = '0;
    for (int i = 0; i < nb; i++) begin
      v = int'(opnd[8*nb-1-8*i -: 8]);
      r[8*nb-1-8*i -: 8] = tab[2047-8*v -: 8];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 3; d++) begin
      exp_st[d] = '0;
      exp_kw[d] = '0;
    end
  endtask

  // Entered at the negedge after the grant cycle; waits for done, checks
  // that the output is held meanwhile, then latency and result.
  task automatic wait_done(input int d, input bit kw, input logic [127:0] opnd);
    int lat;
    int nb;
    logic [127:0] res;
    logic dn;
    nb  = kw ? 4 : 16;
    res = model_sub(opnd, nb);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      dn = kw ? kw_done_w[d] : st_done_w[d];
      if (dn) begin
        lat = k;
        break;
      end
      if (k == 1) chk("busy_running", 128'(busy_w[d]), 128'd1);
      if (kw) chk("kw_out_held", 128'(kw_out_w[d]), 128'(exp_kw[d]));
      else    chk("st_out_held", st_out_w[d], exp_st[d]);
    end
    chk(kw ? "kw_latency" : "st_latency", 128'(lat), 128'(nb / lanes_of(d) + 1));
    if (kw) begin
      chk("kw_result", 128'(kw_out_w[d]), res);
      exp_kw[d] = res[31:0];
    end else begin
      chk("st_result", st_out_w[d], res);
      exp_st[d] = res;
    end
  endtask

  // Single request on one side, released right after the grant
  task automatic run_op(input int d, input bit kw, input logic [127:0] opnd);
    @(negedge clk);
    if (kw) begin
      kw_in[d]  = opnd[31:0];
      kw_req[d] = 1'b1;
    end else begin
      st_in[d]  = opnd;
      st_req[d] = 1'b1;
    end
    #1;
    chk(kw ? "kw_gnt" : "st_gnt", 128'(kw ? kw_gnt_w[d] : st_gnt_w[d]), 128'd1);
    @(negedge clk);
    st_req[d] = 1'b0;
    kw_req[d] = 1'b0;
    wait_done(d, kw, opnd);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int perm [256];
    int j, tmp, ndone;
    logic [127:0] op, op2;
    for (int d = 0; d < 3; d++) begin
      st_req[d] = 1'b0; kw_req[d] = 1'b0; st_in[d] = '0; kw_in[d] = '0;
    end
    reset_model();

    // reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", 128'(busy_w[d]), 128'd0);
      chk("rst_st_out", st_out_w[d], 128'd0);
      chk("rst_kw_out", 128'(kw_out_w[d]), 128'd0);
      chk("rst_done", 128'({st_done_w[d], kw_done_w[d]}), 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // directed vectors
    run_op(0, 1'b0, 128'h00112233445566778899aabbccddeeff);
    chk("vec_st", st_out_w[0], 128'h638293c31bfc33f5c4eeacea4bc12816);
    run_op(0, 1'b1, 128'hcf4f3c09);
    chk("vec_kw", 128'(kw_out_w[0]), 128'h8a84eb01);
    run_op(2, 1'b1, 128'hcf4f3c09);

    // simultaneous requests after reset: KW first, ST granted in kw_done cycle
    pulse_reset();
    @(negedge clk);
    op = 128'h0123456789abcdeffedcba9876543210;
    st_in[0] = op; kw_in[0] = 32'h11223344;
    st_req[0] = 1'b1; kw_req[0] = 1'b1;
    #1;
    chk("tie_kw_gnt", 128'(kw_gnt_w[0]), 128'd1);
    chk("tie_st_gnt", 128'(st_gnt_w[0]), 128'd0);
    @(negedge clk);
    kw_req[0] = 1'b0;
    wait_done(0, 1'b1, 128'h11223344);
    chk("st_gnt_in_kw_done", 128'(st_gnt_w[0]), 128'd1);
    @(negedge clk);
    st_req[0] = 1'b0;
    wait_done(0, 1'b0, op);
    // both again: KW wins (alternation)
    st_req[0] = 1'b1; kw_req[0] = 1'b1;
    kw_in[0] = 32'hdeadbeef; st_in[0] = ~op;
    #1;
    chk("alt_kw_gnt", 128'(kw_gnt_w[0]), 128'd1);
    chk("alt_st_gnt", 128'(st_gnt_w[0]), 128'd0);
    @(negedge clk);
    kw_req[0] = 1'b0;
    wait_done(0, 1'b1, 128'hdeadbeef);
    @(negedge clk);
    st_req[0] = 1'b0;
    wait_done(0, 1'b0, ~op);

    // st_req held for two operands
    @(negedge clk);
    op  = 128'h3243f6a8885a308d313198a2e0370734;
    op2 = 128'h00000000000000000000000000000000;
    st_in[0] = op; st_req[0] = 1'b1;
    #1;
    chk("b2b_gnt1", 128'(st_gnt_w[0]), 128'd1);
    @(negedge clk);
    st_in[0] = op2;
    wait_done(0, 1'b0, op);
    chk("b2b_gnt2", 128'(st_gnt_w[0]), 128'd1);
    @(negedge clk);
    st_req[0] = 1'b0;
    wait_done(0, 1'b0, op2);

    // reset in the middle of an ST operation
    @(negedge clk);
    st_in[0] = 128'hffeeddccbbaa99887766554433221100; st_req[0] = 1'b1;
    @(negedge clk);
    st_req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("mid_rst_busy", 128'(busy_w[0]), 128'd0);
    chk("mid_rst_st_out", st_out_w[0], 128'd0);
    chk("mid_rst_kw_out", 128'(kw_out_w[0]), 128'd0);
    chk("mid_rst_done", 128'(st_done_w[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (st_done_w[0]) ndone++;
    end
    chk("no_done_after_rst", 128'(ndone), 128'd0);
    run_op(0, 1'b0, 128'h00112233445566778899aabbccddeeff);

    // all 256 byte values, shuffled, through each lane width
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int d = 0; d < 3; d++) begin
      for (int s = 0; s < 16; s++) begin
        for (int b = 0; b < 16; b++) op[127-8*b -: 8] = 8'(perm[16*s+b]);
        run_op(d, 1'b0, op);
      end
      for (int s = 0; s < 6; s++) run_op(d, 1'b1, 128'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
